// File: rtl/stfwd_port_arb.sv
// stfwd_port_arb: round-robin arbiter sharing one store-to-load forwarding
// port (storeQue/sbuffer slave side) among NREQ load pipes.
//   s0 : picks one requester (round-robin from rr_ptr), NACKs the others.
//   s1 : routes the owner's paddr/qualifier to the slave and the slave's
//        vaddr_match/data_rdy back to the owner.
//   s2 : routes the slave response to the owner (no stall, one cycle only).
// Ports: clk, rst (async active-high), flush, req_s0_* / req_s1_* / req_s2_*
//   (per-pipe, flat-packed), slv_s0_* / slv_s1_* / slv_s2_* (slave side).
// Optional feature macro: STFWD_ARB_LQIDX_CHK_EN -- checks the returned s2
//   lqIdx against the owner's lqIdx, forces a failed match on mismatch and
//   pulses the registered output lqidx_err.
module stfwd_port_arb #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned LQIDX_W = 6,
  parameter int unsigned SQIDX_W = 6,
  parameter int unsigned PADDR_W = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NREQ-1:0]              req_s0_vld,
  input  logic [NREQ*LQIDX_W-1:0]      req_s0_lqIdx,
  input  logic [NREQ*SQIDX_W-1:0]      req_s0_sqIdx,
  input  logic [NREQ*XLEN-1:0]         req_s0_vaddr,
  input  logic [NREQ*(XLEN/8)-1:0]     req_s0_load_vec,
  output logic [NREQ-1:0]              req_s0_nack,
  input  logic [NREQ-1:0]              req_s1_vld,
  input  logic [NREQ*PADDR_W-1:0]      req_s1_paddr,
  output logic [NREQ-1:0]              req_s1_vaddr_match,
  output logic [NREQ-1:0]              req_s1_data_rdy,
  output logic [NREQ-1:0]              req_s2_rdy,
  output logic [NREQ-1:0]              req_s2_paddr_match,
  output logic [NREQ-1:0]              req_s2_match_failed,
  output logic [NREQ*(XLEN/8)-1:0]     req_s2_match_vec,
  output logic [NREQ*XLEN-1:0]         req_s2_fwd_data,
  output logic                         slv_s0_vld,
  output logic [LQIDX_W-1:0]           slv_s0_lqIdx,
  output logic [SQIDX_W-1:0]           slv_s0_sqIdx,
  output logic [XLEN-1:0]              slv_s0_vaddr,
  output logic [XLEN/8-1:0]            slv_s0_load_vec,
  input  logic                         slv_s1_vaddr_match,
  input  logic                         slv_s1_data_rdy,
  output logic                         slv_s1_vld,
  output logic [PADDR_W-1:0]           slv_s1_paddr,
  input  logic                         slv_s2_rdy,
  input  logic [LQIDX_W-1:0]           slv_s2_lqIdx,
  input  logic                         slv_s2_paddr_match,
  input  logic                         slv_s2_match_failed,
  input  logic [XLEN/8-1:0]            slv_s2_match_vec,
  input  logic [XLEN-1:0]              slv_s2_fwd_data
`ifdef STFWD_ARB_LQIDX_CHK_EN
  ,
  output logic                         lqidx_err
`endif
);

  localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned VEC_W = XLEN / 8;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            s1_own_vld_q, s1_own_vld_d;
  logic [ID_W-1:0] s1_own_id_q, s1_own_id_d;
  logic            s2_own_vld_q, s2_own_vld_d;
  logic [ID_W-1:0] s2_own_id_q, s2_own_id_d;

  logic            s0_any;
  logic [ID_W-1:0] s0_win;
  logic            s0_gnt;
  logic            s2_route;
  logic            s2_lq_bad;

`ifdef STFWD_ARB_LQIDX_CHK_EN
  logic [LQIDX_W-1:0] s1_own_lq_q, s1_own_lq_d;
  logic [LQIDX_W-1:0] s2_own_lq_q, s2_own_lq_d;
  logic               lqidx_err_q, lqidx_err_d;

  assign lqidx_err = lqidx_err_q;
`else
  // Returned lqIdx is only consumed by the optional consistency check.
  logic unused_slv_s2_lqidx;
  assign unused_slv_s2_lqidx = ^slv_s2_lqIdx;
`endif

  // s0: round-robin winner search starting at rr_ptr, grant/NACK, next owner
  always_comb begin
    int unsigned idx;
    idx             = 0;
    s0_any          = 1'b0;
    s0_win          = '0;
    req_s0_nack     = '0;
    slv_s0_lqIdx    = '0;
    slv_s0_sqIdx    = '0;
    slv_s0_vaddr    = '0;
    slv_s0_load_vec = '0;

    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!s0_any && (idx == i) && req_s0_vld[i]) begin
          s0_any = 1'b1;
          s0_win = ID_W'(i);
        end
      end
    end

    s0_gnt     = s0_any & ~flush;
    slv_s0_vld = s0_gnt;

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (s0_any && (s0_win == ID_W'(i))) begin
        slv_s0_lqIdx    = req_s0_lqIdx[i*LQIDX_W +: LQIDX_W];
        slv_s0_sqIdx    = req_s0_sqIdx[i*SQIDX_W +: SQIDX_W];
        slv_s0_vaddr    = req_s0_vaddr[i*XLEN +: XLEN];
        slv_s0_load_vec = req_s0_load_vec[i*VEC_W +: VEC_W];
      end
      req_s0_nack[i] = req_s0_vld[i] & ((s0_win != ID_W'(i)) | flush);
    end

    // Pointer only moves past a pipe that actually won a grant.
    rr_ptr_d = rr_ptr_q;
    if (s0_gnt) begin
      rr_ptr_d = (s0_win == ID_W'(NREQ - 1)) ? '0 : s0_win + ID_W'(1);
    end

    s1_own_vld_d = s0_gnt;
    s1_own_id_d  = s0_win;
`ifdef STFWD_ARB_LQIDX_CHK_EN
    s1_own_lq_d  = slv_s0_lqIdx;
`endif
  end

  // s1: owner qualifier/paddr to slave, slave s1 response back to owner
  always_comb begin
    req_s1_vaddr_match = '0;
    req_s1_data_rdy    = '0;
    slv_s1_vld         = 1'b0;
    slv_s1_paddr       = '0;

    if (s1_own_vld_q) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (s1_own_id_q == ID_W'(i)) begin
          req_s1_vaddr_match[i] = slv_s1_vaddr_match;
          req_s1_data_rdy[i]    = slv_s1_data_rdy;
          slv_s1_vld            = req_s1_vld[i] & ~flush;
          slv_s1_paddr          = req_s1_paddr[i*PADDR_W +: PADDR_W];
        end
      end
    end

    // The owner advances only if it was still alive and presented to the slave.
    s2_own_vld_d = slv_s1_vld;
    s2_own_id_d  = s1_own_id_q;
`ifdef STFWD_ARB_LQIDX_CHK_EN
    s2_own_lq_d  = s1_own_lq_q;
`endif
  end

  // s2: route slave response to owner; responses with no owner are dropped
  always_comb begin
    req_s2_rdy          = '0;
    req_s2_paddr_match  = '0;
    req_s2_match_failed = '0;
    req_s2_match_vec    = '0;
    req_s2_fwd_data     = '0;

    s2_route  = s2_own_vld_q & slv_s2_rdy & ~flush;
`ifdef STFWD_ARB_LQIDX_CHK_EN
    s2_lq_bad = s2_route & (slv_s2_lqIdx != s2_own_lq_q);
`else
    s2_lq_bad = 1'b0;
`endif

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (s2_route && (s2_own_id_q == ID_W'(i))) begin
        req_s2_rdy[i]                      = 1'b1;
        req_s2_paddr_match[i]              = slv_s2_paddr_match & ~s2_lq_bad;
        req_s2_match_failed[i]             = slv_s2_match_failed | s2_lq_bad;
        req_s2_match_vec[i*VEC_W +: VEC_W] = s2_lq_bad ? '0 : slv_s2_match_vec;
        req_s2_fwd_data[i*XLEN +: XLEN]    = slv_s2_fwd_data;
      end
    end

`ifdef STFWD_ARB_LQIDX_CHK_EN
    lqidx_err_d = s2_lq_bad;
`endif
  end

  // Pipeline state; async reset drops every in-flight owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      s1_own_vld_q <= 1'b0;
      s1_own_id_q  <= '0;
      s2_own_vld_q <= 1'b0;
      s2_own_id_q  <= '0;
`ifdef STFWD_ARB_LQIDX_CHK_EN
      s1_own_lq_q  <= '0;
      s2_own_lq_q  <= '0;
      lqidx_err_q  <= 1'b0;
`endif
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      s1_own_vld_q <= s1_own_vld_d;
      s1_own_id_q  <= s1_own_id_d;
      s2_own_vld_q <= s2_own_vld_d;
      s2_own_id_q  <= s2_own_id_d;
`ifdef STFWD_ARB_LQIDX_CHK_EN
      s1_own_lq_q  <= s1_own_lq_d;
      s2_own_lq_q  <= s2_own_lq_d;
      lqidx_err_q  <= lqidx_err_d;
`endif
    end
  end

endmodule

// File: doc/stfwd_port_arb.md
Name: stfwd_port_arb

Overview:
- Round-robin arbiter that shares one store-to-load forwarding port (storeQue/sbuffer slave side) among NREQ load pipes.
- Grants at most one s0 forward request per cycle and NACKs the losers so they replay.
- Tracks the granted owner through s1/s2 and routes s1 match/paddr and s2 responses between that owner and the slave.
- Sits between the load pipes and the storeQue forward logic.

Parameters:
NREQ, 2, number of load pipe requesters (2..4)
XLEN, 64, data/vaddr width
LQIDX_W, 6, lqIdx width
SQIDX_W, 6, sqIdx width
PADDR_W, 40, physical address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  pipeline flush; kills all in-flight forwards
req_s0_vld  in  NREQ  per-pipe s0 forward request
req_s0_lqIdx  in  NREQ*LQIDX_W  per-pipe load lqIdx
req_s0_sqIdx  in  NREQ*SQIDX_W  per-pipe youngest older store sqIdx
req_s0_vaddr  in  NREQ*XLEN  per-pipe load vaddr
req_s0_load_vec  in  NREQ*(XLEN/8)  per-pipe byte mask
req_s0_nack  out  NREQ  request lost arbitration; pipe must replay
req_s1_vld  in  NREQ  pipe still alive in s1
req_s1_paddr  in  NREQ*PADDR_W  translated paddr
req_s1_vaddr_match  out  NREQ  routed slave s1_vaddr_match
req_s1_data_rdy  out  NREQ  routed slave s1_data_rdy
req_s2_rdy  out  NREQ  routed slave s2 response valid
req_s2_paddr_match  out  NREQ  routed
req_s2_match_failed  out  NREQ  routed (may be forced, see below)
req_s2_match_vec  out  NREQ*(XLEN/8)  routed
req_s2_fwd_data  out  NREQ*XLEN  routed
slv_s0_vld / slv_s0_lqIdx / slv_s0_sqIdx / slv_s0_vaddr / slv_s0_load_vec  out  1/LQIDX_W/SQIDX_W/XLEN/XLEN/8  granted s0 request
slv_s1_vaddr_match / slv_s1_data_rdy  in  1/1  slave s1 response
slv_s1_vld / slv_s1_paddr  out  1/PADDR_W  owner s1 qualifier and paddr
slv_s2_rdy / slv_s2_lqIdx / slv_s2_paddr_match / slv_s2_match_failed / slv_s2_match_vec / slv_s2_fwd_data  in  1/LQIDX_W/1/1/XLEN/8/XLEN  slave s2 response

Behaviour:
- State: rr_ptr (clog2 NREQ); s1_own_vld, s1_own_id, s1_own_lq; s2_own_vld, s2_own_id, s2_own_lq.
- Reset: all state 0/invalid; all outputs 0. Unselected requester outputs are always 0.
- s0 (combinational):
  - Winner = first i with req_s0_vld[i], searching from rr_ptr upward with wrap.
  - slv_s0_* = winner fields; slv_s0_vld = any valid & !flush.
  - req_s0_nack[i] = req_s0_vld[i] & (i != winner | flush).
- s0 register: on a grant, s1_own <= {1, winner, lqIdx} and rr_ptr <= (winner+1) mod NREQ. rr_ptr is unchanged when there is no grant or on flush.
- s1 (combinational, only when s1_own_vld):
  - req_s1_vaddr_match/data_rdy[own] = slave values.
  - slv_s1_vld = req_s1_vld[own] & !flush; slv_s1_paddr = req_s1_paddr[own].
- s1 register: s2_own <= s1_own if slv_s1_vld, else invalid.
- s2 (only when s2_own_vld & slv_s2_rdy): route all slv_s2_* to owner; req_s2_rdy[own]=1.
  - slv_s2_rdy while s2_own_vld=0 is dropped.
  - s2_own clears every cycle; there is no s2 stall.
- Latency: s0 grant to s2 response = 2 cycles. Back-to-back grants every cycle are supported (fully pipelined, one owner per stage).
- flush:
  - Suppresses the s0 grant and NACKs all s0 requesters.
  - Deasserts slv_s1_vld so the s1 owner dies.
  - Zeroes req_s2_rdy in the same cycle; next cycle all owners are invalid.
- Async reset mid-operation: owners cleared immediately; in-flight responses are discarded.

Optional Feature:
- Macro STFWD_ARB_LQIDX_CHK_EN.
- Defined: on a routed s2 response with slv_s2_lqIdx != s2_own_lq, the arbiter:
  - forces req_s2_match_failed=1, req_s2_match_vec=0 and req_s2_paddr_match=0;
  - pulses an extra output lqidx_err (1 bit, registered, reset 0) for one cycle.
- Undefined: lqIdx is not stored in s1_own/s2_own, responses pass through unmodified, and there is no lqidx_err port.

Test Plan:
- NREQ=2, rr_ptr=0, both s0_vld, lqIdx 3/7 -> pipe0 granted, slv_s0_lqIdx=3, nack=2'b10. Next cycle both again -> pipe1 granted, nack=2'b01.
- Single grant to pipe1, s1_vld=1, paddr=0x12340; slave s2_rdy with fwd_data=0xDEADBEEF, vec=0x0F -> req_s2_rdy=2'b10 exactly 2 cycles after grant, data routed only to pipe1, pipe0 outputs 0.
- Grant pipe0, then req_s1_vld[0]=0 -> slv_s1_vld=0; slave s2_rdy next cycle -> dropped, req_s2_rdy=0.
- Grants every cycle for 6 cycles alternating pipes -> each s2 response routed to the pipe granted 2 cycles earlier, no loss.
- flush asserted while owners in s0, s1 and s2 -> slv_s0_vld=0, all nack, slv_s1_vld=0, req_s2_rdy=0; rr_ptr unchanged; new grant next cycle.
- With STFWD_ARB_LQIDX_CHK_EN, owner lqIdx 5, slave returns lqIdx 6 with paddr_match=1 -> req_s2_match_failed=1, match_vec=0, paddr_match=0; lqidx_err=1 next cycle.
